// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with BCD add/sub, shift/rotate and N/Z/C/V/H flags behind start/busy/done.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int FUNC_W = 8
) (
    input  logic              phi1,
    input  logic              reset_n,
    input  logic              start,
    input  logic [FUNC_W-1:0] func,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              carry_in,
    input  logic              dec_mode,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              carry_out,
    output logic              overflow,
    output logic              zero,
    output logic              negative,
    output logic              half_carry
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;
    typedef enum logic [3:0] {OP_PASS, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SR, OP_SL, OP_ROR} op_t;

    state_t           r_state;
    op_t              r_op;
    logic             r_dec;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic             r_h;
    logic             r_first;
    logic             r_shift;
    logic [CW-1:0]    r_cnt;

    op_t              w_op;
    logic             w_onehot;
    logic             w_shop;
    logic [WIDTH-1:0] w_rmod;
    logic [CW-1:0]    w_cnt;
    logic [CW-1:0]    w_steps;
    logic             w_bcd;
    logic             w_sub;
    logic             w_arith;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic [4:0]       w_ds;
    logic [4:0]       w_dd;
    logic             w_dc;
    logic [3:0]       w_dig;
    logic             w_h;
    logic             w_v;
    logic [WIDTH-1:0] w_acc;
    logic             w_c;

    // Request decode: shift count saturation / ring modulus and number of EXEC steps.
    always_comb begin
        w_onehot = (func != '0) && ((func & (func - FUNC_W'(1))) == '0);
        w_op = !w_onehot ? OP_PASS : func[0] ? OP_ADD : func[1] ? OP_AND : func[2] ? OP_OR :
               func[3] ? OP_XOR : func[4] ? OP_SR : func[5] ? OP_SL : func[6] ? OP_ROR :
               func[7] ? OP_SUB : OP_PASS;
        w_shop = (w_op == OP_SR) || (w_op == OP_SL) || (w_op == OP_ROR);
        w_rmod = b % WIDTH'(WIDTH + 1);
        w_cnt = (w_op == OP_ROR) ? CW'(w_rmod) : (b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(b);
        w_steps = w_shop ? ((w_cnt == '0) ? '0 : w_cnt - 1'b1) :
                  (dec_mode && (w_op == OP_ADD || w_op == OP_SUB)) ? CW'(NIB - 1) : '0;
    end

    // One EXEC step: whole-word binary op, one BCD nibble, or one shift/rotate bit.
    always_comb begin
        w_sub   = r_op == OP_SUB;
        w_arith = (r_op == OP_ADD) || w_sub;
        w_bcd   = r_dec && w_arith;
        w_bx    = w_sub ? ~r_b : r_b;
        w_sum   = {1'b0, r_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, r_c};
        w_ds    = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_c};
        w_dd    = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'b0, ~r_c};
        w_dc    = w_sub ? ~w_dd[4] : (w_ds > 5'd9);
        w_dig   = w_sub ? w_dd[3:0] - (w_dd[4] ? 4'd6 : 4'd0) : w_ds[3:0] + ((w_ds > 5'd9) ? 4'd6 : 4'd0);
        // H reports borrow for subtraction, carry for addition
        w_h     = w_arith && (w_sub ^ (w_bcd ? w_dc : (w_sum[4] ^ r_a[4] ^ w_bx[4])));
        w_v     = w_arith && !r_dec && (r_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        w_acc   = r_acc;
        w_c     = r_c;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_acc = w_bcd ? {w_dig, r_acc[WIDTH-1:4]} : w_sum[WIDTH-1:0];
                w_c   = w_bcd ? w_dc : w_sum[WIDTH];
            end
            OP_AND: w_acc = r_a & r_b;
            OP_OR:  w_acc = r_a | r_b;
            OP_XOR: w_acc = r_a ^ r_b;
            OP_SR:  if (r_shift) {w_acc, w_c} = {1'b0, r_acc};
            OP_SL:  if (r_shift) {w_c, w_acc} = {r_acc, 1'b0};
            OP_ROR: if (r_shift) {w_acc, w_c} = {r_c, r_acc};
            default: w_acc = r_acc;
        endcase
    end

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_PASS;
            r_dec      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_c        <= 1'b0;
            r_h        <= 1'b0;
            r_first    <= 1'b0;
            r_shift    <= 1'b0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            half_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_LOAD;
                    r_op    <= w_op;
                    r_dec   <= dec_mode;
                    r_a     <= a;
                    r_b     <= b;
                    r_acc   <= a;
                    r_c     <= carry_in;
                    r_h     <= 1'b0;
                    r_first <= 1'b1;
                    r_shift <= w_cnt != '0;
                    r_cnt   <= w_steps;
                end
                S_LOAD: begin
                    r_state <= S_EXEC;
                    busy    <= 1'b1;
                end
                S_EXEC: begin
                    r_acc   <= w_acc;
                    r_c     <= w_c;
                    r_first <= 1'b0;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_first) r_h <= w_h;
                    if (w_bcd) begin
                        r_a <= r_a >> 4;
                        r_b <= r_b >> 4;
                    end
                    if (r_cnt == '0) begin
                        r_state    <= S_DONE;
                        done       <= 1'b1;
                        result     <= w_acc;
                        carry_out  <= w_c;
                        overflow   <= w_v;
                        half_carry <= r_first ? w_h : r_h;
                        zero       <= w_acc == '0;
                        negative   <= w_acc[WIDTH-1];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and seeded-random checks of alu_seq at WIDTH 8 and 16 against an arithmetic model.
module tb_alu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic        start8 = 1'b0, ci8 = 1'b0, dec8 = 1'b0;
    logic [7:0]  func8 = '0, a8 = '0, b8 = '0;
    logic        busy8, done8, c8, v8, z8, n8, h8;
    logic [7:0]  res8;
    logic        start16 = 1'b0, ci16 = 1'b0, dec16 = 1'b0;
    logic [7:0]  func16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, c16, v16, z16, n16, h16;
    logic [15:0] res16;

    int errors = 0;
    int checks = 0;
    logic [15:0] o_res;
    logic        o_c, o_v, o_z, o_n, o_h;
    int          o_lat, o_bc;

    alu_seq #(.WIDTH(8), .FUNC_W(8)) u8 (
        .phi1(clk), .reset_n(rst_n), .start(start8), .func(func8), .a(a8), .b(b8),
        .carry_in(ci8), .dec_mode(dec8), .busy(busy8), .done(done8), .result(res8),
        .carry_out(c8), .overflow(v8), .zero(z8), .negative(n8), .half_carry(h8)
    );
    alu_seq #(.WIDTH(16), .FUNC_W(8)) u16 (
        .phi1(clk), .reset_n(rst_n), .start(start16), .func(func16), .a(a16), .b(b16),
        .carry_in(ci16), .dec_mode(dec16), .busy(busy16), .done(done16), .result(res16),
        .carry_out(c16), .overflow(v16), .zero(z16), .negative(n16), .half_carry(h16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, digit loops and ring rotation; n = EXEC cycles.
    task automatic model(input int w, input logic [7:0] f, input longint av, input longint bv,
                         input bit ci, input bit dec, output longint res, output bit c,
                         output bit v, output bit h, output int n);
        longint m, half, sa, sb, t, st, tn, ring, rot;
        int ci_i, cy, x, y, d, cnt;
        bit sub;
        m = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa = (av >= half) ? av - 2 * half : av;
        sb = (bv >= half) ? bv - 2 * half : bv;
        ci_i = ci;
        res = av; c = ci; v = 0; h = 0; n = 1;
        if ($countones(f) == 1) begin
            if (f[0] || f[7]) begin
                sub = f[7];
                if (!dec) begin
                    t  = sub ? av - bv - (1 - ci_i) : av + bv + ci_i;
                    st = sub ? sa - sb - (1 - ci_i) : sa + sb + ci_i;
                    tn = sub ? (av & 15) - (bv & 15) - (1 - ci_i) : (av & 15) + (bv & 15) + ci_i;
                    res = t & m;
                    c = sub ? (t >= 0) : (t > m);
                    h = sub ? (tn < 0) : (tn > 15);
                    v = (st < -half) || (st >= half);
                end else begin
                    cy = sub ? 1 - ci_i : ci_i;
                    res = 0;
                    n = w / 4;
                    for (int i = 0; i < w / 4; i++) begin
                        x = int'((av >> (4 * i)) & 15);
                        y = int'((bv >> (4 * i)) & 15);
                        if (!sub) begin
                            d = x + y + cy;
                            cy = (d > 9) ? 1 : 0;
                            if (d > 9) d += 6;
                        end else begin
                            d = x - y - cy;
                            cy = (d < 0) ? 1 : 0;
                            if (d < 0) d -= 6;
                        end
                        res |= longint'(d & 15) << (4 * i);
                        if (i == 0) h = cy[0];
                    end
                    c = sub ? !cy[0] : cy[0];
                end
            end
            else if (f[1]) res = av & bv;
            else if (f[2]) res = av | bv;
            else if (f[3]) res = av ^ bv;
            else if (f[4] || f[5]) begin
                cnt = (bv > w) ? w : int'(bv);
                n = (cnt == 0) ? 1 : cnt;
                if (cnt > 0) begin
                    res = f[4] ? av >> cnt : (av << cnt) & m;
                    c = f[4] ? ((av >> (cnt - 1)) & 1) != 0 : ((av >> (w - cnt)) & 1) != 0;
                end
            end else begin
                cnt = int'(bv % (w + 1));
                n = (cnt == 0) ? 1 : cnt;
                ring = (longint'(ci) << w) | av;
                rot = ((ring >> cnt) | (ring << (w + 1 - cnt))) & ((longint'(1) << (w + 1)) - 1);
                res = rot & m;
                c = ((rot >> w) & 1) != 0;
            end
        end
    endtask

    // Caller sits at a negedge with the DUT idle; returns at the negedge of the cycle after done.
    task automatic run_op(input int w, input logic [7:0] f, input longint av, input longint bv,
                          input bit ci, input bit dec, input bit hold, input string tag);
        longint er;
        bit ec, ev, eh;
        int en, lat, bc;
        logic dn;
        model(w, f, av, bv, ci, dec, er, ec, ev, eh, en);
        if (w == 8) begin
            func8 = f; a8 = 8'(av); b8 = 8'(bv); ci8 = ci; dec8 = dec; start8 = 1'b1;
        end else begin
            func16 = f; a16 = 16'(av); b16 = 16'(bv); ci16 = ci; dec16 = dec; start16 = 1'b1;
        end
        @(negedge clk);
        start8 = hold && (w == 8);
        start16 = hold && (w == 16);
        lat = 0; bc = 0; dn = 1'b0;
        while (!dn && lat < 64) begin
            @(negedge clk);
            lat++;
            dn = (w == 8) ? done8 : done16;
            if ((w == 8) ? busy8 : busy16) bc++;
        end
        start8 = 1'b0;
        start16 = 1'b0;
        o_res = (w == 8) ? {8'h00, res8} : res16;
        o_c = (w == 8) ? c8 : c16;
        o_v = (w == 8) ? v8 : v16;
        o_z = (w == 8) ? z8 : z16;
        o_n = (w == 8) ? n8 : n16;
        o_h = (w == 8) ? h8 : h16;
        o_lat = lat; o_bc = bc;
        chk($sformatf("%s latency", tag), lat, en + 1);
        chk($sformatf("%s busy", tag), bc, en + 1);
        chk($sformatf("%s result", tag), o_res, 32'(er));
        chk($sformatf("%s C", tag), o_c, ec);
        chk($sformatf("%s V", tag), o_v, ev);
        chk($sformatf("%s H", tag), o_h, eh);
        chk($sformatf("%s Z", tag), o_z, er == 0);
        chk($sformatf("%s N", tag), o_n, ((er >> (w - 1)) & 1) != 0);
        @(negedge clk);
        chk($sformatf("%s done pulse", tag), (w == 8) ? {done8, busy8} : {done16, busy16}, 0);
    endtask

    initial begin
        logic [7:0] f;
        longint av, bv, m;
        int w, dcount;
        void'($urandom(32'd20240611));
        repeat (2) @(negedge clk);
        chk("reset 8", {busy8, done8, res8, c8, v8, z8, n8, h8}, 0);
        chk("reset 16", {busy16, done16, res16, c16, v16, z16, n16, h16}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8, 8'h01, 'h7F, 'h01, 0, 0, 0, "sum bin");
        chk("sum bin res", o_res, 'h80);
        chk("sum bin flags CVNZH", {o_c, o_v, o_n, o_z, o_h}, 5'b01101);
        chk("sum bin edges", o_lat, 2);
        run_op(8, 8'h01, 'h58, 'h46, 1, 1, 0, "sum dec");
        chk("sum dec res", o_res, 'h05);
        chk("sum dec CV", {o_c, o_v}, 2'b10);
        chk("sum dec edges", o_lat, 3);
        run_op(8, 8'h80, 'h00, 'h01, 1, 0, 0, "sub 00-01");
        chk("sub 00-01 res", o_res, 'hFF);
        chk("sub 00-01 CNV", {o_c, o_n, o_v}, 3'b010);
        run_op(8, 8'h80, 'h80, 'h01, 1, 0, 0, "sub 80-01");
        chk("sub 80-01 res", o_res, 'h7F);
        chk("sub 80-01 CV", {o_c, o_v}, 2'b11);
        run_op(8, 8'h80, 'h32, 'h19, 1, 1, 0, "sub dec");
        chk("sub dec res", o_res, 'h13);
        run_op(8, 8'h10, 'h81, 3, 0, 0, 0, "sr3");
        chk("sr3 res C", {o_res[7:0], o_c}, {8'h10, 1'b0});
        chk("sr3 busy cycles", o_bc, 4);
        run_op(8, 8'h20, 'h81, 8, 0, 0, 0, "sl8");
        chk("sl8 res C Z", {o_res[7:0], o_c, o_z}, {8'h00, 2'b11});
        run_op(8, 8'h40, 'h01, 1, 0, 0, 0, "ror1");
        chk("ror1 res C", {o_res[7:0], o_c}, {8'h00, 1'b1});
        run_op(8, 8'h20, 'hA5, 0, 1, 0, 0, "sl0");
        chk("sl0 res C", {o_res[7:0], o_c}, {8'hA5, 1'b1});
        run_op(8, 8'h10, 'hF0, 200, 1, 0, 0, "sr sat");
        run_op(8, 8'h00, 'h00, 'h55, 1, 0, 0, "func0");
        chk("func0 C Z", {o_c, o_z}, 2'b11);
        run_op(8, 8'h06, 'h9C, 'h33, 0, 1, 0, "func multi");
        run_op(8, 8'h02, 'hF0, 'h3C, 1, 1, 0, "and dec");

        run_op(16, 8'h01, 'h1234, 'h5678, 0, 1, 1, "hold dec16");
        chk("hold dec16 res", o_res, 'h6912);
        dcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (done16) dcount++;
        end
        chk("hold single done", dcount, 0);

        func16 = 8'h01; a16 = 16'h9999; b16 = 16'h0001; dec16 = 1'b1; ci16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy/done/res", {busy16, done16, res16}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done16) dcount++;
        end
        chk("abort no done", dcount, 0);
        run_op(16, 8'h01, 'h0999, 'h0001, 0, 1, 0, "after abort");
        chk("after abort res", o_res, 'h1000);

        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8 : 16;
            m = (longint'(1) << w) - 1;
            for (int i = 0; i < 1000; i++) begin
                f = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
                av = longint'($urandom) & m;
                bv = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, w + 2)) : longint'($urandom) & m;
                run_op(w, f, av, bv, 1'($urandom), 1'($urandom), 0, $sformatf("rnd w%0d #%0d", w, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
